hog_pixel_feeder: RTL and testbench
===================================

# hog_pixel_feeder

Bus-slave pixel source for the HOG pipeline. It accepts 128-bit pixel words written by the HPS over the bridge bus and buffers them in a small word FIFO. It serializes the enabled bytes of each word into an 8-bit valid/ready pixel stream that feeds the HOG input stage in place of the switch/key input. It also exposes status and count registers, and raises an interrupt when a batch has fully drained.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- ADDR_WIDTH, 5, bridge word-address width
- BUS_WIDTH, 128, bridge data width
- BUS_BYTES, 16, BUS_WIDTH/8; byte lanes and pixels per word
- FIFO_DEPTH, 4, word FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  register word address
- bus_enable  in  1  transaction request; held high by master until ack
- r_wbar  in  1  1 = read, 0 = write
- write_data  in  BUS_WIDTH  write payload
- byte_enable  in  BUS_BYTES  per-byte write lanes
- read_data  out  BUS_WIDTH  read payload, valid while ack is high
- ack  out  1  one-cycle transaction acknowledge
- irq  out  1  level interrupt (pending & enable)
- pixel_out  out  DATA_WIDTH  current pixel
- pixel_valid  out  1  pixel_out valid
- pixel_ready  in  1  downstream accepts pixel when valid & ready

## Operation
- Register map (word address):
  - 0 DATA (W): pushes {write_data, byte_enable} as one FIFO entry. A write with byte_enable == 0 is acked but does not push.
  - 1 STATUS (R): [7:0] FIFO level (words), [8] full, [9] empty, [10] irq_pending, [11] irq_enable, [12] streaming (pixel_valid). Other bits are 0.
  - 2 CTRL (W, byte 0 only): bit0 irq_enable (stored), bit1 flush (self-clearing), bit2 irq_clear (self-clearing).
  - 3 COUNT (R): [31:0] pixels accepted downstream since reset/flush, wraps at 2^32.
  - Other addresses: reads return 0, writes are ignored; both are acked.
- Bus FSM states: IDLE, ACK.
  - IDLE→ACK when bus_enable is high, unless it is a DATA write with the FIFO full; that write stalls in IDLE with no ack until a slot frees.
  - ACK lasts one cycle, then returns to IDLE. While in ACK, bus_enable is not re-sampled, so a held request is not double-counted.
- Serializer: the head FIFO entry is read with a byte index.
  - pixel_out = byte[idx] of the head word, with byte 0 = write_data[7:0] emitted first.
  - idx always points at the lowest enabled lane at or above the current position; disabled lanes are skipped with zero bubbles.
  - On valid & ready, idx advances to the next enabled lane. If there is none, the entry pops and the next entry starts at its lowest enabled lane on the following cycle.
- pixel_valid = FIFO not empty. pixel_out is held stable while valid & !ready.
- irq_pending is set on the cycle the last pixel of the last buffered entry is accepted (FIFO goes empty through a pop). It is cleared by irq_clear or flush. If set and clear occur in the same cycle, set wins.
- Flush: FIFO emptied, idx reset, COUNT zeroed, irq_pending cleared. An in-flight pixel is dropped even if pixel_valid was high. irq_enable is retained.

## Timing
- Reset values: ack 0, read_data 0, irq 0, pixel_valid 0, pixel_out 0, FIFO empty, COUNT 0, irq_enable 0, irq_pending 0, FSM IDLE.
- Request sampled at cycle T (not stalled): ack = 1 in T+1. Read data is registered and valid in T+1. A DATA push becomes visible in the FIFO at T+1.
- Write to empty FIFO: pixel_valid = 1 in T+1 at the earliest (push registered at the T edge). The first pixel can be accepted in T+1.
- Throughput: 1 pixel/cycle sustained, including across word boundaries and skipped lanes.
- Full FIFO: a push is accepted only if there is space at the sampling edge; there is no same-cycle bypass from a pop. A stalled write is acked in the cycle after the pop that frees a slot is registered.
- STATUS/COUNT reads reflect state at the sampling edge T.
- irq follows irq_pending & irq_enable with one register stage.
- rst mid-stream: all state clears on the next edge; pixel_valid is 0 the following cycle.

## Test plan
- Write DATA 0x0F0E…0100, byte_enable 0xFFFF, ready held high → 16 consecutive pixels 0x00..0x0F, one per cycle. COUNT = 16, irq_pending = 1; irq = 1 only after CTRL = 0x1.
- byte_enable 0x8001 with bytes 0xAA (lane 0) and 0x55 (lane 15) → pixels 0xAA then 0x55 back-to-back with no gap; entry pops.
- Hold pixel_ready low and write 5 words → 4 writes are acked and the 5th stalls with ack 0. STATUS reads level 4 with full = 1. After ready goes high for 16 accepts, the 5th write is acked.
- Backpressure: toggle ready every cycle → pixel_out stable while not accepted. No pixel is lost or duplicated, and COUNT = total enabled bytes.
- Mid-stream CTRL flush (0x2) after 5 pixels → next cycle pixel_valid = 0, level 0, COUNT 0, irq_pending 0.
- irq_clear asserted in the same cycle as the drain-complete event → irq_pending remains 1. A later CTRL = 0x5 clears it and irq drops.

Source files
------------

// File: rtl/hog_pixel_feeder_if.sv
// Bridge-bus and pixel-stream bundle for the HOG pixel feeder.
// The master is the HPS bridge plus the downstream HOG input stage.
interface hog_pixel_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int BUS_WIDTH  = 128,
    parameter int BUS_BYTES  = BUS_WIDTH / 8
) ();
    logic [ADDR_WIDTH-1:0] addr;
    logic                  bus_enable;
    logic                  r_wbar;
    logic [BUS_WIDTH-1:0]  write_data;
    logic [BUS_BYTES-1:0]  byte_enable;
    logic [BUS_WIDTH-1:0]  read_data;
    logic                  ack;
    logic                  irq;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic                  pixel_valid;
    logic                  pixel_ready;

    modport master (
        output addr,
        output bus_enable,
        output r_wbar,
        output write_data,
        output byte_enable,
        output pixel_ready,
        input  read_data,
        input  ack,
        input  irq,
        input  pixel_out,
        input  pixel_valid
    );

    modport slave (
        input  addr,
        input  bus_enable,
        input  r_wbar,
        input  write_data,
        input  byte_enable,
        input  pixel_ready,
        output read_data,
        output ack,
        output irq,
        output pixel_out,
        output pixel_valid
    );
endinterface

// File: rtl/hog_pixel_feeder.sv
// Bridge-bus slave that buffers 128-bit pixel words in a small FIFO and
// serializes their enabled bytes into an 8-bit valid/ready pixel stream.
module hog_pixel_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int BUS_WIDTH  = 128,
    parameter int BUS_BYTES  = BUS_WIDTH / 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    hog_pixel_feeder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(BUS_BYTES);
    localparam int LW = PW + 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT  = ADDR_WIDTH'(3);

    typedef enum logic [0:0] {
        IDLE,
        ACK
    } state_e;

    state_e                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  irq_q, irq_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_pend_q, irq_pend_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [BUS_BYTES-1:0]  done_q, done_d;
    logic [31:0]           count_q, count_d;

    logic [BUS_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
    logic [BUS_BYTES-1:0]  be_mem_q   [FIFO_DEPTH];

    logic                  full;
    logic                  empty;
    logic                  valid;
    logic                  req;
    logic                  stall;
    logic                  take;
    logic                  push;
    logic                  ctrl_wr;
    logic                  flush;
    logic                  irq_clr;
    logic                  accept;
    logic                  pop;
    logic                  drained;
    logic [BUS_WIDTH-1:0]  head_data;
    logic [BUS_BYTES-1:0]  head_be;
    logic [BUS_BYTES-1:0]  rem;
    logic [BUS_BYTES-1:0]  lane;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] head_pix;
    logic [BUS_WIDTH-1:0]  rd_mux;

    // Bus decode: a DATA write into a full FIFO is held off, not dropped.
    always_comb begin
        full    = (level_q == LW'(FIFO_DEPTH));
        empty   = (level_q == '0);
        valid   = !empty;
        req     = (state_q == IDLE) && bus.bus_enable;
        stall   = req && !bus.r_wbar && (bus.addr == ADDR_DATA) && full;
        take    = req && !stall;
        push    = take && !bus.r_wbar && (bus.addr == ADDR_DATA)
                  && (|bus.byte_enable);
        ctrl_wr = take && !bus.r_wbar && (bus.addr == ADDR_CTRL)
                  && bus.byte_enable[0];
        flush   = ctrl_wr && bus.write_data[1];
        irq_clr = ctrl_wr && bus.write_data[2];
    end

    // Lanes not yet emitted from the head word; idx is the lowest of them.
    always_comb begin
        head_data = data_mem_q[rd_ptr_q];
        head_be   = be_mem_q[rd_ptr_q];
        rem       = head_be & ~done_q;
        idx       = '0;
        for (int i = BUS_BYTES - 1; i >= 0; i--) begin
            if (rem[i]) begin
                idx = IW'(i);
            end
        end
        lane      = '0;
        lane[idx] = 1'b1;
        head_pix  = head_data[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        accept  = valid && bus.pixel_ready && !flush;
        pop     = accept && ((rem & ~lane) == '0);
        drained = pop && (level_q == LW'(1)) && !push;
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (bus.addr == ADDR_STATUS): begin
                rd_mux[LW-1:0] = level_q;
                rd_mux[8]      = full;
                rd_mux[9]      = empty;
                rd_mux[10]     = irq_pend_q;
                rd_mux[11]     = irq_en_q;
                rd_mux[12]     = valid;
            end
            (bus.addr == ADDR_COUNT): begin
                rd_mux[31:0] = count_q;
            end
            default: begin
                rd_mux = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (bus.r_wbar) begin
                        rdata_d = rd_mux;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        count_d  = count_q + 32'(accept);
        done_d   = done_q;
        if (accept) begin
            done_d = pop ? '0 : (done_q | lane);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            count_d  = '0;
            done_d   = '0;
        end
    end

    // A drain in the same cycle as a clear leaves the interrupt pending.
    always_comb begin
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        if (ctrl_wr) begin
            irq_en_d = bus.write_data[0];
        end
        if (drained) begin
            irq_pend_d = 1'b1;
        end else if (irq_clr || flush) begin
            irq_pend_d = 1'b0;
        end
        irq_d = irq_pend_q & irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            done_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= bus.write_data;
            be_mem_q[wr_ptr_q]   <= bus.byte_enable;
        end
    end

    assign bus.read_data   = rdata_q;
    assign bus.ack         = ack_q;
    assign bus.irq         = irq_q;
    assign bus.pixel_valid = valid;
    assign bus.pixel_out   = valid ? head_pix : '0;
endmodule

// File: tb/tb_hog_pixel_feeder.sv
// Directed bench for hog_pixel_feeder: bus writes feed a pixel scoreboard,
// a negedge monitor pops and compares every accepted pixel.
module tb_hog_pixel_feeder;
    localparam int AW = 5;
    localparam int BW = 128;
    localparam int BB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hog_pixel_feeder_if #(
        .DATA_WIDTH(8), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .BUS_BYTES(BB)
    ) bus ();

    hog_pixel_feeder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .BUS_BYTES(BB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    int         run_len = 0;
    bit         prev_acc = 1'b0;
    bit         hold = 1'b0;
    logic [7:0] hold_pix = '0;

    bit   toggle_en = 1'b0;
    logic tog = 1'b0;
    logic rdy_man = 1'b0;
    assign bus.pixel_ready = toggle_en ? tog : rdy_man;

    always @(posedge clk) begin
        if (toggle_en) begin
            #1;
            tog = ~tog;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cond(input string tag, input bit cond);
        n_chk++;
        assert (cond) else begin
            n_fail++;
            $error("FAIL %s: observed 0 expected 1", tag);
        end
    endtask

    always @(negedge clk) begin
        bit acc;
        acc = !rst && bus.pixel_valid && bus.pixel_ready;
        if (!rst && hold && bus.pixel_valid) begin
            check("hold_stable", 128'(bus.pixel_out), 128'(hold_pix));
        end
        hold = !rst && bus.pixel_valid && !bus.pixel_ready;
        hold_pix = bus.pixel_out;
        if (acc) begin
            run_len = prev_acc ? run_len + 1 : 1;
            check_cond("pixel_expected", exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("pixel", 128'(bus.pixel_out), 128'(exp_q.pop_front()));
            end
        end
        prev_acc = acc;
    end

    function automatic logic [127:0] make_word(input logic [7:0] base);
        logic [127:0] w;
        for (int i = 0; i < BB; i++) begin
            w[i*8 +: 8] = base + 8'(i);
        end
        return w;
    endfunction

    task automatic push_exp(input logic [127:0] d, input logic [15:0] be);
        for (int i = 0; i < BB; i++) begin
            if (be[i]) exp_q.push_back(d[i*8 +: 8]);
        end
    endtask

    task automatic bus_start(input logic [AW-1:0] a, input logic rw,
                             input logic [127:0] d, input logic [15:0] be);
        @(posedge clk);
        #1;
        bus.addr = a;
        bus.r_wbar = rw;
        bus.write_data = d;
        bus.byte_enable = be;
        bus.bus_enable = 1'b1;
    endtask

    task automatic bus_wait(input string tag, output logic [127:0] rd);
        int cyc;
        cyc = 0;
        rd = '0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.ack) begin
                rd = bus.read_data;
                break;
            end
        end
        check_cond({tag, "_ack"}, bus.ack == 1'b1);
        @(posedge clk);
        #1;
        bus.bus_enable = 1'b0;
    endtask

    task automatic bus_wr(input string tag, input logic [AW-1:0] a,
                          input logic [127:0] d, input logic [15:0] be);
        logic [127:0] rd;
        if (a == '0) push_exp(d, be);
        bus_start(a, 1'b0, d, be);
        bus_wait(tag, rd);
    endtask

    task automatic bus_rd(input string tag, input logic [AW-1:0] a,
                          output logic [127:0] rd);
        bus_start(a, 1'b1, '0, '0);
        bus_wait(tag, rd);
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a,
                            input logic [127:0] exp);
        logic [127:0] rd;
        bus_rd(tag, a, rd);
        check(tag, rd, exp);
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (cyc < 400 && bus.pixel_valid) begin
            @(negedge clk);
            cyc++;
        end
        check_cond(tag, !bus.pixel_valid);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd;
        logic [127:0] w;
        int n;
        bus.addr = '0;
        bus.r_wbar = 1'b0;
        bus.write_data = '0;
        bus.byte_enable = '0;
        bus.bus_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 128'(bus.ack), 128'(0));
        check("rst_rdata", bus.read_data, 128'(0));
        check("rst_irq", 128'(bus.irq), 128'(0));
        check("rst_valid", 128'(bus.pixel_valid), 128'(0));
        check("rst_pixel", 128'(bus.pixel_out), 128'(0));
        rd_check("rst_status", 5'd1, 128'h200);
        rd_check("rst_count", 5'd3, 128'd0);

        // Full word, ready held high
        rdy_man = 1'b1;
        bus_wr("w_full", 5'd0, 128'h0F0E0D0C0B0A09080706050403020100,
               16'hFFFF);
        wait_drain("drain_full");
        check("run_full", 128'(run_len), 128'(16));
        rd_check("count16", 5'd3, 128'd16);
        rd_check("status_pend", 5'd1, 128'h600);
        check("irq_masked", 128'(bus.irq), 128'(0));
        bus_wr("ctrl_en", 5'd2, 128'h1, 16'h0001);
        repeat (2) @(negedge clk);
        check("irq_on", 128'(bus.irq), 128'(1));
        rd_check("status_en", 5'd1, 128'hE00);

        // Sparse lanes 0 and 15
        w = '0;
        w[7:0] = 8'hAA;
        w[127:120] = 8'h55;
        bus_wr("w_sparse", 5'd0, w, 16'h8001);
        wait_drain("drain_sparse");
        check("run_sparse", 128'(run_len), 128'(2));
        rd_check("count18", 5'd3, 128'd18);

        // Fill FIFO with ready low, fifth write stalls
        rdy_man = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_wr("w_fill", 5'd0, make_word(8'(16 * (k + 1))), 16'hFFFF);
        end
        rd_check("status_full", 5'd1, 128'h1D04);
        push_exp(make_word(8'd80), 16'hFFFF);
        bus_start(5'd0, 1'b0, make_word(8'd80), 16'hFFFF);
        repeat (5) begin
            @(negedge clk);
            check_cond("stall_noack", bus.ack == 1'b0);
        end
        @(posedge clk);
        #1;
        rdy_man = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.ack) break;
        end
        check("stall_ack_cyc", 128'(n), 128'(18));
        @(posedge clk);
        #1;
        bus.bus_enable = 1'b0;
        wait_drain("drain_fill");
        rd_check("count98", 5'd3, 128'd98);

        // Flush after five accepted pixels
        rdy_man = 1'b0;
        bus_wr("w_flush", 5'd0, make_word(8'h60), 16'hFFFF);
        rdy_man = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rdy_man = 1'b0;
        rd_check("count103", 5'd3, 128'd103);
        bus_wr("ctrl_flush", 5'd2, 128'h3, 16'h0001);
        exp_q.delete();
        check("flush_valid", 128'(bus.pixel_valid), 128'(0));
        rd_check("flush_status", 5'd1, 128'hA00);
        rd_check("flush_count", 5'd3, 128'd0);
        check("flush_irq", 128'(bus.irq), 128'(0));

        // Backpressure: ready toggles every cycle
        toggle_en = 1'b1;
        bus_wr("bp0", 5'd0, make_word(8'h80), 16'hF0F0);
        bus_wr("bp_nobe", 5'd0, make_word(8'h90), 16'h0000);
        bus_wr("bp1", 5'd0, make_word(8'hA0), 16'h0001);
        bus_wr("bp2", 5'd0, make_word(8'hB0), 16'hFFFF);
        wait_drain("drain_bp");
        toggle_en = 1'b0;
        rd_check("count25", 5'd3, 128'd25);
        check("sb_empty", 128'(exp_q.size()), 128'(0));

        // irq_clear coincident with drain
        rdy_man = 1'b0;
        bus_wr("ctrl_clr", 5'd2, 128'h5, 16'h0001);
        rd_check("status_clr", 5'd1, 128'hA00);
        bus_wr("w_one", 5'd0, 128'h77, 16'h0001);
        bus_start(5'd2, 1'b0, 128'h5, 16'h0001);
        rdy_man = 1'b1;
        bus_wait("ctrl_race", rd);
        rd_check("status_race", 5'd1, 128'hE00);
        check("irq_race", 128'(bus.irq), 128'(1));
        bus_wr("ctrl_clr2", 5'd2, 128'h5, 16'h0001);
        rd_check("status_clr2", 5'd1, 128'hA00);
        check("irq_off", 128'(bus.irq), 128'(0));

        // Unmapped addresses
        rd_check("rd_unmapped", 5'd7, 128'd0);
        bus_wr("wr_unmapped", 5'd9, make_word(8'h11), 16'hFFFF);
        rd_check("status_unmapped", 5'd1, 128'hA00);

        // Reset mid-stream
        rdy_man = 1'b0;
        bus_wr("w_rst", 5'd0, make_word(8'hC0), 16'hFFFF);
        rdy_man = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst2_valid", 128'(bus.pixel_valid), 128'(0));
        check("rst2_irq", 128'(bus.irq), 128'(0));
        rd_check("rst2_count", 5'd3, 128'd0);
        rd_check("rst2_status", 5'd1, 128'h200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
